// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache store buffer: geometry, size codes and the entry layout.
package dcache_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = 2;
  localparam int BLK_W    = 29;

  localparam logic [1:0] WR_SIZE_B = 2'b00;
  localparam logic [1:0] WR_SIZE_H = 2'b01;
  localparam logic [1:0] WR_SIZE_W = 2'b10;
  localparam logic [1:0] WR_SIZE_D = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } sb_entry_t;
endpackage

// File: rtl/sb_hazard_cmp.sv
// One hazard comparator: flags a load whose 8B block equals a valid store's block or the block after it.
module sb_hazard_cmp
  import dcache_pkg::*;
(
  input  logic             vld,
  input  logic [BLK_W-1:0] blk,
  input  logic [BLK_W-1:0] ld_blk,
  output logic             hit
);
  logic [BLK_W-1:0] blk_nxt;

  // block+1 wraps at 2^29 and covers a store straddling into the next block
  assign blk_nxt = blk + 1'b1;
  assign hit     = vld & ((ld_blk == blk) | (ld_blk == blk_nxt));
endmodule

// File: rtl/dcache_store_buffer.sv
// In-order store queue feeding the dcache write port; stalls only when full and flags load hazards.
module dcache_store_buffer
  import dcache_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int PTR_W  = SB_PTR_W,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_address,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              wr_req_valid,
  input  logic              wr_req_ready,
  output logic [31:0]       wr_req_address,
  output logic [DATA_W-1:0] wr_req_data,
  output logic [1:0]        wr_size,
  input  logic [31:0]       ld_check_addr,
  output logic              ld_hazard,
  output logic [PTR_W:0]    count,
  output logic              empty
);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DEPTH-1:0]  vld;
  logic [31:0]       addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic              push;
  logic              pop;
  logic [DEPTH:0]    hit;
  logic              unused_ld_lsb;

  // No full-bypass: st_ready depends only on the registered count
  assign st_ready     = (count != FULL_CNT);
  assign wr_req_valid = (count != '0);
  assign empty        = (count == '0);
  assign push         = st_valid & st_ready;
  assign pop          = wr_req_valid & wr_req_ready;

  assign wr_req_address = addr_q[head];
  assign wr_req_data    = data_q[head];
  assign wr_size        = size_q[head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) begin
        tail      <= tail + 1'b1;
        vld[tail] <= 1'b1;
      end
      if (pop) begin
        head      <= head + 1'b1;
        vld[head] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is not reset; entry validity lives in vld
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_address;
      data_q[tail] <= st_data;
      size_q[tail] <= st_size;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent_cmp
    sb_hazard_cmp u_cmp (
      .vld    (vld[i]),
      .blk    (addr_q[i][31:3]),
      .ld_blk (ld_check_addr[31:3]),
      .hit    (hit[i])
    );
  end

  // The store being accepted this cycle is older than the load
  sb_hazard_cmp u_cmp_in (
    .vld    (push),
    .blk    (st_address[31:3]),
    .ld_blk (ld_check_addr[31:3]),
    .hit    (hit[DEPTH])
  );

  assign ld_hazard     = |hit;
  assign unused_ld_lsb = ^ld_check_addr[2:0];
endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed bench for dcache_store_buffer with a queue-based reference model checked every cycle.
module tb_dcache_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_address;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        wr_req_valid;
  logic        wr_req_ready;
  logic [31:0] wr_req_address;
  logic [63:0] wr_req_data;
  logic [1:0]  wr_size;
  logic [31:0] ld_check_addr;
  logic        ld_hazard;
  logic [2:0]  count;
  logic        empty;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  s;
  } ent_t;
  ent_t q[$];

  dcache_store_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_address     (st_address),
    .st_data        (st_data),
    .st_size        (st_size),
    .wr_req_valid   (wr_req_valid),
    .wr_req_ready   (wr_req_ready),
    .wr_req_address (wr_req_address),
    .wr_req_data    (wr_req_data),
    .wr_size        (wr_size),
    .ld_check_addr  (ld_check_addr),
    .ld_hazard      (ld_hazard),
    .count          (count),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a load is blocked if its block equals a pending (or accepted-now) store's block or block+1
  function automatic logic model_hazard();
    bit [28:0] l;
    bit [28:0] b;
    logic      h;
    l = ld_check_addr[31:3];
    h = 1'b0;
    foreach (q[i]) begin
      b = q[i].a[31:3];
      if (l == b || l == b + 29'd1) h = 1'b1;
    end
    if (st_valid && q.size() != DEPTH) begin
      b = st_address[31:3];
      if (l == b || l == b + 29'd1) h = 1'b1;
    end
    return h;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) q.delete();
    else begin
      bit   do_push;
      bit   do_pop;
      ent_t e;
      do_push = st_valid && (q.size() != DEPTH);
      do_pop  = (q.size() != 0) && wr_req_ready;
      e.a = st_address;
      e.d = st_data;
      e.s = st_size;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("count", count, q.size());
      check("empty", empty, q.size() == 0);
      check("st_ready", st_ready, q.size() != DEPTH);
      check("wr_req_valid", wr_req_valid, q.size() != 0);
      check("ld_hazard", ld_hazard, model_hazard());
      if (q.size() != 0) begin
        check("head_addr", wr_req_address, q[0].a);
        check("head_data", wr_req_data, q[0].d);
        check("head_size", wr_size, q[0].s);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    st_valid   = 1'b1;
    st_address = a;
    st_data    = d;
    st_size    = s;
  endtask

  initial begin
    reset         = 1'b0;
    st_valid      = 1'b0;
    st_address    = '0;
    st_data       = '0;
    st_size       = '0;
    wr_req_ready  = 1'b0;
    ld_check_addr = 32'hFFFF_0000;
    repeat (2) tick();
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_wr_valid", wr_req_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 3'd0);
    reset = 1'b1;
    tick();

    // single store round trip
    offer(32'h1000, 64'h1122334455667788, 2'b11);
    tick();
    st_valid = 1'b0;
    check("t1_valid", wr_req_valid, 1'b1);
    check("t1_addr", wr_req_address, 32'h1000);
    check("t1_data", wr_req_data, 64'h1122334455667788);
    check("t1_size", wr_size, 2'b11);
    wr_req_ready = 1'b1;
    tick();
    wr_req_ready = 1'b0;
    check("t1_empty", empty, 1'b1);

    // fill to full while the dcache stalls
    for (int i = 0; i < 4; i++) begin
      offer(32'h100 + 32'(i * 8), 64'hA0 + 64'(i), 2'(i));
      tick();
    end
    offer(32'h900, 64'hDEAD, 2'b01);
    tick();
    check("t2_count", count, 3'd4);
    check("t2_ready", st_ready, 1'b0);
    check("t2_head", wr_req_address, 32'h100);

    // full with push+pop: only the pop happens
    wr_req_ready = 1'b1;
    tick();
    st_valid = 1'b0;
    check("t3_count", count, 3'd3);
    check("t3_ready", st_ready, 1'b1);
    check("t3_head", wr_req_address, 32'h108);
    tick();
    check("t4_pre_count", count, 3'd2);

    // steady push+pop at count 2, pointers wrap
    for (int i = 0; i < 10; i++) begin
      offer(32'h8000 + 32'(i * 16), 64'hC000 + 64'(i), 2'b10);
      tick();
      check("t4_count", count, 3'd2);
    end
    st_valid = 1'b0;
    check("t4_head", wr_req_address, 32'h8080);
    repeat (3) tick();
    check("t4_drained", empty, 1'b1);

    // hazard checks
    wr_req_ready = 1'b0;
    offer(32'h2006, 64'h5, 2'b10);
    tick();
    st_valid = 1'b0;
    ld_check_addr = 32'h2008;
    #1 check("t5_hz_next_blk", ld_hazard, 1'b1);
    ld_check_addr = 32'h2010;
    #1 check("t5_hz_clear", ld_hazard, 1'b0);
    offer(32'h3000, 64'h6, 2'b11);
    ld_check_addr = 32'h3004;
    #1 check("t5_hz_inflight", ld_hazard, 1'b1);
    tick();
    offer(32'h4000, 64'h7, 2'b11);
    tick();
    st_valid = 1'b0;
    check("t6_pre_count", count, 3'd3);

    // asynchronous reset mid-drain
    wr_req_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("t6_count", count, 3'd0);
    check("t6_valid", wr_req_valid, 1'b0);
    check("t6_hazard", ld_hazard, 1'b0);
    tick();
    #2 reset = 1'b1;
    tick();
    wr_req_ready = 1'b0;
    offer(32'h5000, 64'h99, 2'b00);
    tick();
    st_valid = 1'b0;
    check("t6_first_out", wr_req_address, 32'h5000);
    check("t6_count_after", count, 3'd1);
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
